fb_rect_writer: RTL and testbench
=================================

Name: fb_rect_writer

Overview:
- Write-side engine for the dual-port framebuffer RAM. The VGA scan-out logic reads this RAM on its other port.
- Accepts rectangle-fill commands (origin, size, 24-bit RGB colour) from the board/piece renderer over a valid/ready handshake.
- Emits one pixel write per clock into the RAM write port, with screen clipping.
- Framebuffer layout: linear, row-major, addr = y*SCREEN_WIDTH + x, data = {R,G,B}.

Parameters:
- SCREEN_WIDTH, 640, pixels per row; row stride of the framebuffer.
- SCREEN_HEIGHT, 480, rows per frame.
- COLOR_DEPTH, 8, bits per channel; wr_data width is 3*COLOR_DEPTH.

Ports:
- clk  in  1  pixel-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fill command valid.
- req_ready  out  1  engine can accept a command.
- req_x  in  10  left column of rectangle.
- req_y  in  10  top row of rectangle.
- req_w  in  10  width in pixels.
- req_h  in  10  height in pixels.
- req_color  in  3*COLOR_DEPTH  fill colour {R,G,B}.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  19  RAM write address.
- wr_data  out  3*COLOR_DEPTH  RAM write data.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Clock and reset: clk is the clock; reset_n is the reset, asynchronous, active-low.
- Reset values: state=IDLE, req_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. All counters are 0.
- Outputs are registered. wr_en/wr_addr/wr_data change only on the clk edge.

States:
- IDLE:
  - req_ready=1.
  - Accept on req_valid && req_ready. Latch x, y, w, h, color. Go to SETUP.
- SETUP (1 cycle):
  - x_end = min(x+w, SCREEN_WIDTH); y_end = min(y+h, SCREEN_HEIGHT). Use 11-bit arithmetic, no overflow.
  - If x>=SCREEN_WIDTH, y>=SCREEN_HEIGHT, w==0 or h==0, go to DONE with no writes.
  - Otherwise row_base = y*SCREEN_WIDTH; col=x; row=y. Go to FILL.
- FILL:
  - Each cycle register wr_en=1, wr_addr=row_base+col, wr_data=color.
  - col increments. At col==x_end-1 the row wraps: col=x, row+1, row_base += SCREEN_WIDTH.
  - At the last pixel (col==x_end-1 && row==y_end-1), go to DONE.
  - Throughput is 1 pixel/clock, no stalls.
- DONE (1 cycle):
  - wr_en=0, done=1. Return to IDLE.

Handshake and status:
- req_ready=0 in SETUP/FILL/DONE. Commands presented then are held off, not dropped.
- busy=1 in SETUP, FILL and DONE.

Write stream:
- Pixel write order is row-major, left to right, top to bottom.
- No address outside 0..SCREEN_WIDTH*SCREEN_HEIGHT-1 is ever written.
- wr_en is low in all states except FILL cycles.

Latency:
- First wr_en is 2 clocks after the accept edge.
- done asserts the cycle after the last write.
- Clipped area of N pixels occupies N+2 cycles from accept to done.

Boundary conditions:
- Partial off-screen rectangles are clipped on the right and bottom edges. Only the visible pixels are written.
- Reset asserted mid-FILL: wr_en drops immediately (async). Engine returns to IDLE; the partial rectangle stays in RAM.
- req_valid held high across done: the next command is accepted in the first IDLE cycle. That gives 1 idle cycle between bursts.

Test Plan:
- Basic fill: x=0,y=0,w=2,h=2,color=FF0000 -> 4 writes, addr 0,1,640,641, data FF0000; done pulse 1 cycle after addr 641; 6 cycles accept-to-done.
- Right/bottom clip: x=638,y=479,w=4,h=3 -> exactly 2 writes, addr 307198 and 307199; done follows.
- Degenerate sizes:
  - w=0,h=5 -> zero wr_en cycles; done 2 cycles after accept.
  - x=640,w=10 -> same response.
- Full screen: x=0,y=0,w=640,h=480,color=00FF00 -> 307200 consecutive writes, addr 0..307199 with no gaps; req_ready=0 throughout.
- Back-to-back: two commands with req_valid held -> second accepted exactly 1 cycle after first done; no overlap of write streams.
- Reset mid-operation: assert reset_n=0 during FILL of a 10x10 rect -> wr_en=0, busy=0, req_ready=1 without waiting for clk; a new command after release behaves as in scenario 1.

Source files
------------

// File: rtl/fb_rect_writer.sv
`default_nettype none
// ============================================================================
//  Module   : fb_rect_writer
//  Purpose  : Write-side engine for the dual-port framebuffer RAM. Accepts
//             rectangle-fill commands over a valid/ready handshake and emits
//             one clipped pixel write per clock, row-major, into the RAM
//             write port (addr = y*SCREEN_WIDTH + x, data = {R,G,B}).
//  Ports    : clk, reset_n          - pixel clock, async active-low reset
//             req_valid/req_ready   - command handshake
//             req_x/y/w/h/color     - rectangle origin, size and fill colour
//             wr_en/wr_addr/wr_data - registered RAM write port
//             busy                  - command in progress
//             done                  - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module fb_rect_writer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [9:0]               req_x,
  input  logic [9:0]               req_y,
  input  logic [9:0]               req_w,
  input  logic [9:0]               req_h,
  input  logic [3*COLOR_DEPTH-1:0] req_color,
  output logic                     wr_en,
  output logic [18:0]              wr_addr,
  output logic [3*COLOR_DEPTH-1:0] wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int          C_CW     = 3 * COLOR_DEPTH;
  localparam logic [10:0] C_SW     = 11'(SCREEN_WIDTH);
  localparam logic [10:0] C_SH     = 11'(SCREEN_HEIGHT);
  localparam logic [18:0] C_STRIDE = 19'(SCREEN_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched command
  logic [9:0]      r_x;
  logic [9:0]      r_y;
  logic [9:0]      r_w;
  logic [9:0]      r_h;
  logic [C_CW-1:0] r_color;

  // Clipped extents (exclusive) and walk counters
  logic [10:0] r_x_end;
  logic [10:0] r_y_end;
  logic [9:0]  r_col;
  logic [9:0]  r_row;
  logic [18:0] r_row_base;

  // Registered outputs
  logic            r_wr_en;
  logic [18:0]     r_wr_addr;
  logic [C_CW-1:0] r_wr_data;
  logic            r_done;

  logic            w_wr_en_next;
  logic            w_done_next;

  // 11-bit sums cannot overflow for 10-bit operands.
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_empty;
  logic        w_last_col;
  logic        w_last_row;

  assign w_x_sum = {1'b0, r_x} + {1'b0, r_w};
  assign w_y_sum = {1'b0, r_y} + {1'b0, r_h};
  assign w_x_end = (w_x_sum > C_SW) ? C_SW : w_x_sum;
  assign w_y_end = (w_y_sum > C_SH) ? C_SH : w_y_sum;

  // Nothing visible: origin off the right/bottom edge or zero-sized.
  assign w_empty = ({1'b0, r_x} >= C_SW) || ({1'b0, r_y} >= C_SH) ||
                   (r_w == 10'd0) || (r_h == 10'd0);

  // Extents are only compared in FILL, where they are at least origin+1.
  assign w_last_col = ({1'b0, r_col} == (r_x_end - 11'd1));
  assign w_last_row = ({1'b0, r_row} == (r_y_end - 11'd1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_wr_en_next = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next = w_empty ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        w_wr_en_next = 1'b1;
        if (w_last_col && w_last_row) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: command latch, clipping setup, pixel walk, output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= w_wr_en_next;
      r_done  <= w_done_next;
      if (w_wr_en_next) begin
        r_wr_addr <= r_row_base + 19'(r_col);
        r_wr_data <= r_color;
      end
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_x     <= req_x;
            r_y     <= req_y;
            r_w     <= req_w;
            r_h     <= req_h;
            r_color <= req_color;
          end
        end
        ST_SETUP: begin
          r_x_end    <= w_x_end;
          r_y_end    <= w_y_end;
          r_row_base <= 19'(r_y) * C_STRIDE;
          r_col      <= r_x;
          r_row      <= r_y;
        end
        ST_FILL: begin
          if (w_last_col) begin
            r_col      <= r_x;
            r_row      <= r_row + 10'd1;
            r_row_base <= r_row_base + C_STRIDE;
          end else begin
            r_col <= r_col + 10'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_rect_writer
//  Purpose  : Self-checking bench for fb_rect_writer. Commands are issued by
//             a stimulus process that pushes the expected write stream and
//             done pulse (with the cycle each must appear) into a queue; a
//             monitor pops and compares whenever the DUT writes or signals
//             done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fb_rect_writer;

  localparam int SW  = 640;
  localparam int SH  = 480;
  localparam int TMO = 60000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_x = '0;
  logic [9:0]  req_y = '0;
  logic [9:0]  req_w = '0;
  logic [9:0]  req_h = '0;
  logic [23:0] req_color = '0;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;

  fb_rect_writer #(
    .SCREEN_WIDTH (SW),
    .SCREEN_HEIGHT(SH),
    .COLOR_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_w    (req_w),
    .req_h    (req_h),
    .req_color(req_color),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; outputs registered at edge k are seen at
  // the following falling edge while cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    int unsigned addr;
    int unsigned data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: enumerate the rectangle, keep on-screen pixels in
  // raster order; pixel k appears accept+2+k, done one cycle after the last.
  function automatic int push_model(input int x, input int y, input int w, input int h,
                                    input int unsigned color, input int acc);
    int   k = 0;
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if ((x + c) < SW && (y + r) < SH) begin
          e.is_done = 1'b0;
          e.addr    = (y + r) * SW + (x + c);
          e.data    = color;
          e.cyc     = acc + 2 + k;
          exp_q.push_back(e);
          k++;
        end
      end
    end
    e.is_done = 1'b1;
    e.addr    = 0;
    e.data    = 0;
    e.cyc     = acc + 2 + k;
    exp_q.push_back(e);
    return k;
  endfunction

  // ---------------------------------------------------------------- monitor
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_event: %s due at cycle %0d not seen by cycle %0d",
                 exp_q[0].is_done ? "done" : "write", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (wr_en) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d at cycle %0d, nothing expected", wr_addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_not_done_slot", 64'(mon_e.is_done), 64'd0);
          check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
          check("wr_data", 64'(wr_data), 64'(mon_e.data));
          check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("ready_low_while_writing", 64'(req_ready), 64'd0);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: at cycle %0d, nothing expected", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_slot", 64'(mon_e.is_done), 64'd1);
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic send(input int x, input int y, input int w, input int h,
                      input int unsigned color, input bit hold,
                      output int acc, output int npix);
    @(negedge clk);
    req_x     = 10'(x);
    req_y     = 10'(y);
    req_w     = 10'(w);
    req_h     = 10'(h);
    req_color = 24'(color);
    req_valid = 1'b1;
    acc       = -1;
    npix      = 0;
    for (int t = 0; t < TMO; t++) begin
      if (req_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: command not accepted within %0d cycles", TMO);
      req_valid = 1'b0;
    end else begin
      npix = push_model(x, y, w, h, color, acc);
      @(posedge clk);
      #1;
      check("busy_after_accept", 64'(busy), 64'd1);
      check("ready_low_after_accept", 64'(req_ready), 64'd0);
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < TMO && exp_q.size() > 0; t++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int a1, a2, n1, n2, w0;

    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset_n = 1'b1;

    // Basic 2x2 fill.
    send(0, 0, 2, 2, 32'hFF0000, 1'b0, a1, n1);
    check("basic_pixel_count", 64'(n1), 64'd4);
    drain();

    // Right/bottom clip: only 307198 and 307199 are visible.
    send(638, 479, 4, 3, 32'h123456, 1'b0, a1, n1);
    check("clip_pixel_count", 64'(n1), 64'd2);
    drain();

    // Degenerate sizes: done two cycles after accept, no writes.
    send(10, 10, 0, 5, 32'hABCDEF, 1'b0, a1, n1);
    drain();
    send(640, 20, 10, 4, 32'h0000FF, 1'b0, a1, n1);
    drain();

    // Wide strip clipped at the bottom, ending at the last framebuffer address.
    send(0, 440, 640, 100, 32'h00FF00, 1'b0, a1, n1);
    check("strip_pixel_count", 64'(n1), 64'd25600);
    drain();

    // Back-to-back with req_valid held: second accept one cycle after done.
    send(100, 200, 3, 2, 32'h111111, 1'b1, a1, n1);
    send(300, 100, 2, 3, 32'h222222, 1'b0, a2, n2);
    check("back_to_back_accept_cycle", 64'(a2), 64'(a1 + n1 + 3));
    drain();

    // Randomised commands, some off-screen or clipped, some held back-to-back.
    for (int i = 0; i < 16; i++) begin
      send($urandom_range(0, 700), $urandom_range(0, 520),
           $urandom_range(0, 24), $urandom_range(0, 24),
           $urandom & 32'hFFFFFF, (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0, a1, n1);
    end
    drain();

    // Reset during FILL of a 10x10 rectangle.
    w0 = n_writes;
    send(5, 5, 10, 10, 32'h777777, 1'b0, a1, n1);
    while (cyc < a1 + 6) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_reset_wr_en", 64'(wr_en), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_ready", 64'(req_ready), 64'd1);
    check("mid_reset_done", 64'(done), 64'd0);
    check("writes_before_reset", 64'(n_writes - w0), 64'd5);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // After release the engine behaves as from a clean start.
    send(0, 0, 2, 2, 32'hFF0000, 1'b0, a1, n1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
